// File: rtl/acct_store_responder_if.sv
// Controller-to-storage record channel: request strobe/fields in, busy and response out.
// The controller drives the master side; the record store is the slave.
interface acct_store_responder_if;
  logic        C_in_valid;
  logic        C_r_wb;
  logic [7:0]  C_addr;
  logic [31:0] C_data_w;
  logic        C_busy;
  logic        C_out_valid;
  logic [31:0] C_data_r;
  logic        C_miss;

  modport master (
    output C_in_valid, C_r_wb, C_addr, C_data_w,
    input  C_busy, C_out_valid, C_data_r, C_miss
  );

  modport slave (
    input  C_in_valid, C_r_wb, C_addr, C_data_w,
    output C_busy, C_out_valid, C_data_r, C_miss
  );
endinterface

// File: rtl/acct_store_responder.sv
// Account record store: 256 x 32-bit records with per-entry valid bits, answering one
// outstanding read/write at a time after a fixed, parameterised latency.
module acct_store_responder #(
  parameter int unsigned RD_LAT = 4,
  parameter int unsigned WR_LAT = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  acct_store_responder_if.slave bus
);

  typedef enum logic [1:0] {SIdle, SRdWait, SWrWait, SResp} state_e;

  localparam logic [3:0] RdLoad = 4'(RD_LAT - 1);
  localparam logic [3:0] WrLoad = 4'(WR_LAT - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        r_wb_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic [255:0] valid_q;
  logic [31:0] mem [256];

  logic        busy_q;
  logic        out_valid_q;
  logic [31:0] data_r_q;
  logic        miss_q;

  logic        resp_rd;
  logic [7:0]  resp_addr;
  logic [31:0] resp_wdata;
  logic [31:0] resp_data;
  logic        resp_miss;
  logic [3:0]  load;
  logic        commit;

  // Response fields come straight from the inputs when a latency-1 request skips the wait.
  always_comb begin
    resp_rd    = r_wb_q;
    resp_addr  = addr_q;
    resp_wdata = wdata_q;
    if (state_q == SIdle) begin
      resp_rd    = bus.C_r_wb;
      resp_addr  = bus.C_addr;
      resp_wdata = bus.C_data_w;
    end
    resp_data = '0;
    resp_miss = 1'b0;
    if (resp_rd) begin
      if (valid_q[resp_addr]) resp_data = mem[resp_addr];
      else                    resp_miss = 1'b1;
    end else begin
      resp_miss = (resp_wdata[31:24] != resp_addr);
    end
  end

  assign load   = bus.C_r_wb ? RdLoad : WrLoad;
  assign commit = (state_q == SResp) && !r_wb_q && (wdata_q[31:24] == addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SIdle;
      cnt_q       <= '0;
      r_wb_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      valid_q     <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      data_r_q    <= '0;
      miss_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      data_r_q    <= '0;
      miss_q      <= 1'b0;
      unique case (state_q)
        SIdle: begin
          if (bus.C_in_valid) begin
            r_wb_q  <= bus.C_r_wb;
            addr_q  <= bus.C_addr;
            wdata_q <= bus.C_data_w;
            busy_q  <= 1'b1;
            if (load == 4'd0) begin
              state_q     <= SResp;
              cnt_q       <= '0;
              out_valid_q <= 1'b1;
              data_r_q    <= resp_data;
              miss_q      <= resp_miss;
            end else begin
              state_q <= bus.C_r_wb ? SRdWait : SWrWait;
              cnt_q   <= load;
            end
          end
        end
        SRdWait, SWrWait: begin
          if (cnt_q == 4'd0) begin
            state_q     <= SResp;
            out_valid_q <= 1'b1;
            data_r_q    <= resp_data;
            miss_q      <= resp_miss;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        SResp: begin
          state_q <= SIdle;
          busy_q  <= 1'b0;
          if (commit) valid_q[addr_q] <= 1'b1;
        end
      endcase
    end
  end

  // Record data carries no reset; the valid bits alone gate visibility.
  always_ff @(posedge clk) begin
    if (commit) mem[addr_q] <= wdata_q;
  end

  assign bus.C_busy      = busy_q;
  assign bus.C_out_valid = out_valid_q;
  assign bus.C_data_r    = data_r_q;
  assign bus.C_miss      = miss_q;

endmodule
